// File: rtl/taxi_pkg.sv
// ---------------------------------------------------------------------------
// taxi_pkg
//   Types and constants shared by the taxi meter blocks.
//   trip_state_t   : trip state machine encoding (IDLE / RUN / PAUSE)
//   METER_W        : width of the metre count driven to mileage_display
//   MAX_METERS_DEF : default saturation ceiling for the metre count
//   WAIT_W         : width of the waiting-seconds counter
// ---------------------------------------------------------------------------
package taxi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } trip_state_t;

  localparam int METER_W        = 20;
  localparam int MAX_METERS_DEF = 99999;
  localparam int WAIT_W         = 16;

endpackage

// File: rtl/pulse_sync_edge.sv
// ---------------------------------------------------------------------------
// pulse_sync_edge
//   Brings an asynchronous level into the clk domain and flags its rising
//   edges. Also used for the fare-button inputs.
//   clk  in  system clock, rising-edge
//   rst  in  asynchronous reset, active-high
//   din  in  raw asynchronous input
//   rise out registered one-cycle pulse per rising edge of din
// A rise of din sampled at edge k makes rise high after edge k+2, so a
// consumer acting on rise updates its state at edge k+3.
// ---------------------------------------------------------------------------
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // NOTE: every clocked register uses <= so all flops sample their inputs
  // from before the edge; blocking here would collapse the s1->s2->s3 chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/mileage_counter.sv
// ---------------------------------------------------------------------------
// mileage_counter
//   Taxi odometer front end: synchronises the wheel sensor, counts metres per
//   trip and runs the IDLE / RUN / PAUSE trip state machine.
//   Optional waiting timer built when WAIT_TIMER_EN is defined; otherwise
//   wait_sec is tied to zero and the port list is unchanged.
// Parameters
//   CLK_HZ           clk frequency, sets the 1 s prescaler (waiting timer)
//   METERS_PER_PULSE metres added per wheel pulse, 1..15
//   MAX_METERS       saturation ceiling, < 2^20
// Ports
//   clk       in   system clock, rising-edge
//   rst       in   asynchronous reset, active-high
//   wheel_raw in   raw wheel sensor, asynchronous, one rise per revolution
//   start     in   1-cycle pulse, begin a new trip (clears trip data)
//   pause     in   1-cycle pulse, passenger waiting
//   resume    in   1-cycle pulse, continue the trip
//   stop      in   1-cycle pulse, end the trip
//   meters    out  metres this trip (to mileage_display.i)
//   running   out  state == RUN
//   paused    out  state == PAUSE
//   sat       out  sticky, meters reached MAX_METERS
//   wait_sec  out  whole seconds spent in PAUSE this trip
// ---------------------------------------------------------------------------
module mileage_counter
  import taxi_pkg::*;
#(
  parameter int CLK_HZ           = 1000,
  parameter int METERS_PER_PULSE = 1,
  parameter int MAX_METERS       = MAX_METERS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wheel_raw,
  input  logic               start,
  input  logic               pause,
  input  logic               resume,
  input  logic               stop,
  output logic [METER_W-1:0] meters,
  output logic               running,
  output logic               paused,
  output logic               sat,
  output logic [WAIT_W-1:0]  wait_sec
);

  // Reject configurations the arithmetic below cannot honour.
  if (CLK_HZ < 1 || METERS_PER_PULSE < 1 || METERS_PER_PULSE > 15 ||
      MAX_METERS < 1 || MAX_METERS >= (1 << METER_W)) begin : g_param_check
    $error("mileage_counter: illegal parameter set");
  end

  trip_state_t        state;
  logic               wheel_rise;
  logic               trip_clear;
  logic               count_en;
  logic [METER_W:0]   next_sum;

  pulse_sync_edge u_wheel_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (wheel_raw),
    .rise (wheel_rise)
  );

  // start clears the trip in every state unless a coincident stop wins
  // (stop is ignored in IDLE, so there start always takes effect).
  assign trip_clear = start && ((state == IDLE) || !stop);

  // A wheel edge coinciding with a trip clear is dropped; with pause or stop
  // it still counts because RUN is the pre-edge state.
  assign count_en = (state == RUN) && wheel_rise && !trip_clear;

  // One extra bit so the ceiling compare cannot be fooled by a wrap.
  assign next_sum = {1'b0, meters} + (METER_W + 1)'(METERS_PER_PULSE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      meters <= '0;
      sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          if (stop)       state <= IDLE;
          else if (start) state <= RUN;
          else if (pause) state <= PAUSE;
        end
        PAUSE: begin
          if (stop)        state <= IDLE;
          else if (start)  state <= RUN;
          else if (resume) state <= RUN;
        end
        default: state <= IDLE;
      endcase

      if (trip_clear) begin
        meters <= '0;
        sat    <= 1'b0;
      end else if (count_en) begin
        if (next_sum >= (METER_W + 1)'(MAX_METERS)) begin
          meters <= METER_W'(MAX_METERS);
          sat    <= 1'b1;
        end else begin
          meters <= next_sum[METER_W-1:0];
        end
      end
    end
  end

  assign running = (state == RUN);
  assign paused  = (state == PAUSE);

`ifdef WAIT_TIMER_EN
  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PRE_W-1:0]  prescale;
  logic [WAIT_W-1:0] wait_cnt;
  logic              enter_pause;

  // Same conditions as the RUN -> PAUSE arc above.
  assign enter_pause = (state == RUN) && pause && !stop && !start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
      wait_cnt <= '0;
    end else begin
      // A partial second left over from an earlier pause is discarded.
      if (enter_pause) begin
        prescale <= '0;
      end else if (state == PAUSE) begin
        if (prescale == PRE_W'(CLK_HZ - 1)) begin
          prescale <= '0;
        end else begin
          prescale <= prescale + 1'b1;
        end
      end

      if (trip_clear) begin
        wait_cnt <= '0;
      end else if (state == PAUSE && prescale == PRE_W'(CLK_HZ - 1) &&
                   wait_cnt != {WAIT_W{1'b1}}) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign wait_sec = wait_cnt;
`else
  assign wait_sec = '0;
`endif

endmodule

// File: tb/tb_mileage_counter.sv
// ---------------------------------------------------------------------------
// tb_mileage_counter
//   Directed bench for mileage_counter. u_dut runs with one metre per pulse
//   and a 100-cycle second; u_sat runs with ten metres per pulse to reach the
//   99999 ceiling. Inputs change just after the falling edge, outputs are
//   sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mileage_counter;

  logic        clk;
  logic        rst;

  logic        wheel_raw, start, pause, resume, stop;
  logic [19:0] meters;
  logic        running, paused, sat;
  logic [15:0] wait_sec;

  logic        s_wheel, s_start, s_pause, s_resume, s_stop;
  logic [19:0] s_meters;
  logic        s_running, s_paused, s_sat;
  logic [15:0] s_wait_sec;

  int tests_run    = 0;
  int tests_failed = 0;

  mileage_counter #(
    .CLK_HZ           (100),
    .METERS_PER_PULSE (1),
    .MAX_METERS       (99999)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .wheel_raw (wheel_raw),
    .start     (start),
    .pause     (pause),
    .resume    (resume),
    .stop      (stop),
    .meters    (meters),
    .running   (running),
    .paused    (paused),
    .sat       (sat),
    .wait_sec  (wait_sec)
  );

  mileage_counter #(
    .CLK_HZ           (1000),
    .METERS_PER_PULSE (10),
    .MAX_METERS       (99999)
  ) u_sat (
    .clk       (clk),
    .rst       (rst),
    .wheel_raw (s_wheel),
    .start     (s_start),
    .pause     (s_pause),
    .resume    (s_resume),
    .stop      (s_stop),
    .meters    (s_meters),
    .running   (s_running),
    .paused    (s_paused),
    .sat       (s_sat),
    .wait_sec  (s_wait_sec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: passes the rising edge, returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Command bits ordered {stop, start, pause, resume}.
  task automatic cmd(input logic [3:0] c);
    {stop, start, pause, resume} = c;
    tick();
    {stop, start, pause, resume} = 4'b0000;
  endtask

  // Full wheel pulse; on return its count (if any) is visible.
  task automatic wheel_pulse();
    wheel_raw = 1'b1;
    ticks(2);
    wheel_raw = 1'b0;
    ticks(2);
  endtask

  // Wheel pulse whose synchronised edge lands on the same clock as command c.
  task automatic wheel_with_cmd(input logic [3:0] c);
    wheel_raw = 1'b1;
    ticks(3);
    cmd(c);
    wheel_raw = 1'b0;
    ticks(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(3);
    tests_run++;
    if ({meters, running, paused, sat, wait_sec} !== {20'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      tests_failed++;
      $display("FAIL reset_values: meters=%0d run=%b pau=%b sat=%b wait=%0d, want all 0",
               meters, running, paused, sat, wait_sec);
    end
    rst = 1'b0;
    tick();
    // Wheel activity in IDLE after reset must not count.
    wheel_pulse();
    tests_run++;
    if (meters !== 20'd0) begin
      tests_failed++;
      $display("FAIL idle_no_count: meters=%0d want 0", meters);
    end
  endtask

  task automatic test_count_latency();
    cmd(4'b0100);
    tests_run++;
    if (running !== 1'b1 || meters !== 20'd0) begin
      tests_failed++;
      $display("FAIL start_run: run=%b meters=%0d want 1/0", running, meters);
    end
    for (int i = 0; i < 5; i++) begin
      wheel_raw = 1'b1;
      ticks(3);
      tests_run++;
      if (meters !== 20'(i)) begin
        tests_failed++;
        $display("FAIL latency_early[%0d]: meters=%0d want %0d", i, meters, i);
      end
      tick();
      tests_run++;
      if (meters !== 20'(i + 1)) begin
        tests_failed++;
        $display("FAIL latency_k3[%0d]: meters=%0d want %0d", i, meters, i + 1);
      end
      wheel_raw = 1'b0;
      ticks(6);
    end
    tests_run++;
    if (meters !== 20'd5 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL five_pulses: meters=%0d run=%b want 5/1", meters, running);
    end
  endtask

  task automatic test_saturation();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 9999; i++) begin
      s_wheel = 1'b1;
      tick();
      s_wheel = 1'b0;
      tick();
    end
    ticks(3);
    tests_run++;
    if (s_meters !== 20'd99990 || s_sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_preload: meters=%0d sat=%b want 99990/0", s_meters, s_sat);
    end
    for (int i = 0; i < 2; i++) begin
      s_wheel = 1'b1;
      ticks(2);
      s_wheel = 1'b0;
      ticks(2);
      tests_run++;
      if (s_meters !== 20'd99999 || s_sat !== 1'b1) begin
        tests_failed++;
        $display("FAIL sat_ceiling[%0d]: meters=%0d sat=%b want 99999/1", i, s_meters, s_sat);
      end
    end
    // Restart clears the sticky flag.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    tests_run++;
    if (s_meters !== 20'd0 || s_sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_clear: meters=%0d sat=%b want 0/0", s_meters, s_sat);
    end
  endtask

  task automatic test_pause_resume();
    cmd(4'b0100);
    for (int i = 0; i < 3; i++) wheel_pulse();
    cmd(4'b0010);
    tests_run++;
    if (meters !== 20'd3 || paused !== 1'b1 || running !== 1'b0) begin
      tests_failed++;
      $display("FAIL enter_pause: meters=%0d pau=%b run=%b want 3/1/0", meters, paused, running);
    end
    for (int i = 0; i < 4; i++) wheel_pulse();
    tests_run++;
    if (meters !== 20'd3) begin
      tests_failed++;
      $display("FAIL pause_hold: meters=%0d want 3", meters);
    end
    cmd(4'b0001);
    wheel_pulse();
    tests_run++;
    if (meters !== 20'd4 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL resume_count: meters=%0d run=%b want 4/1", meters, running);
    end
    cmd(4'b1000);
    wheel_pulse();
    tests_run++;
    if (meters !== 20'd4 || running !== 1'b0 || paused !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_hold: meters=%0d run=%b pau=%b want 4/0/0", meters, running, paused);
    end
  endtask

  task automatic test_simultaneous();
    cmd(4'b0100);
    cmd(4'b1010);
    tests_run++;
    if (running !== 1'b0 || paused !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_pause: run=%b pau=%b want 0/0", running, paused);
    end
    cmd(4'b0100);
    wheel_pulse();
    wheel_pulse();
    wheel_with_cmd(4'b0010);
    tests_run++;
    if (meters !== 20'd3 || paused !== 1'b1) begin
      tests_failed++;
      $display("FAIL edge_with_pause: meters=%0d pau=%b want 3/1", meters, paused);
    end
    wheel_with_cmd(4'b0100);
    tests_run++;
    if (meters !== 20'd0 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL edge_with_start: meters=%0d run=%b want 0/1", meters, running);
    end
    wheel_pulse();
    wheel_with_cmd(4'b1000);
    tests_run++;
    if (meters !== 20'd2 || running !== 1'b0 || paused !== 1'b0) begin
      tests_failed++;
      $display("FAIL edge_with_stop: meters=%0d run=%b pau=%b want 2/0/0", meters, running, paused);
    end
  endtask

  task automatic test_wait_timer();
    logic [15:0] exp_wait;
`ifdef WAIT_TIMER_EN
    exp_wait = 16'd3;
`else
    exp_wait = 16'd0;
`endif
    cmd(4'b0100);
    cmd(4'b0010);
    ticks(350);
    tests_run++;
    if (wait_sec !== exp_wait || paused !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_350: wait=%0d pau=%b want %0d/1", wait_sec, paused, exp_wait);
    end
    cmd(4'b0001);
    ticks(150);
    tests_run++;
    if (wait_sec !== exp_wait) begin
      tests_failed++;
      $display("FAIL wait_hold_run: wait=%0d want %0d", wait_sec, exp_wait);
    end
    cmd(4'b0100);
    tests_run++;
    if (wait_sec !== 16'd0) begin
      tests_failed++;
      $display("FAIL wait_clear: wait=%0d want 0", wait_sec);
    end
  endtask

  task automatic test_async_reset();
    cmd(4'b0100);
    for (int i = 0; i < 42; i++) wheel_pulse();
    tests_run++;
    if (meters !== 20'd42) begin
      tests_failed++;
      $display("FAIL preload_42: meters=%0d want 42", meters);
    end
    #2 rst = 1'b1;
    #1;
    // No clock edge has passed since rst rose.
    tests_run++;
    if (meters !== 20'd0 || running !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: meters=%0d run=%b want 0/0", meters, running);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) wheel_pulse();
    tests_run++;
    if (meters !== 20'd0 || running !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: meters=%0d run=%b want 0/0", meters, running);
    end
    cmd(4'b0100);
    wheel_pulse();
    tests_run++;
    if (meters !== 20'd1) begin
      tests_failed++;
      $display("FAIL post_reset_start: meters=%0d want 1", meters);
    end
  endtask

  initial begin
    rst       = 1'b1;
    wheel_raw = 1'b0;
    {stop, start, pause, resume} = 4'b0000;
    s_wheel = 1'b0;
    s_start = 1'b0;
    s_pause = 1'b0;
    s_resume = 1'b0;
    s_stop  = 1'b0;
    @(negedge clk);
    test_reset();
    test_count_latency();
    test_saturation();
    test_pause_resume();
    test_simultaneous();
    test_wait_timer();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
